// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard event generator.
package ps2_pkg;

    // Prefix bytes that modify or suppress the following scancode
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] PS2_PAUSE     = 8'hE1;
    // Bytes remaining in the Pause sequence after its leading E1
    localparam logic [2:0] PS2_PAUSE_LEN = 3'd7;

    // Field positions inside the 11-bit ps2_key event word
    localparam int KEY_TGL     = 10;
    localparam int KEY_PRS     = 9;
    localparam int KEY_EXT     = 8;
    localparam int KEY_CODE_HI = 7;
    localparam int KEY_CODE_LO = 0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one asynchronous PS/2 line and debounces it: the output
// follows the input only after FILTER_LEN consecutive identical samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic line_in,
    output logic line_out
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] stable_cnt;

    // 2-FF synchronizer plus run-length counter; idle PS/2 lines are high
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            line_out   <= 1'b1;
            stable_cnt <= '0;
        end else begin
            sync_1 <= line_in;
            sync_2 <= sync_1;
            if (sync_2 == line_out) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(FILTER_LEN - 1)) begin
                line_out   <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_gen.sv
// Frames PS/2 keyboard packets, folds E0/F0 prefixes, swallows the Pause
// sequence and publishes one toggle-marked event word per key action.
module ps2_key_gen
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        key_stb,
    output logic        frame_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic            clk_filt;
    logic            data_filt;
    logic            clk_filt_q;
    logic            fe;

    ps2_state_t      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [TO_W-1:0] to_cnt;
    logic            ext;
    logic            brk;
    logic [2:0]      skip;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .line_in  (ps2_clk_in),
        .line_out (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .line_in  (ps2_data_in),
        .line_out (data_filt)
    );

    // Delayed filtered clock for falling-edge detection
    always_ff @(posedge clk_sys) begin
        if (RESET) clk_filt_q <= 1'b1;
        else       clk_filt_q <= clk_filt;
    end

    assign fe = clk_filt_q & ~clk_filt;

    // Frame FSM, timeout watchdog and prefix/event logic with registered outputs
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip      <= '0;
            ps2_key   <= 11'h000;
            key_stb   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_stb   <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE || fe) to_cnt <= '0;
            else                     to_cnt <= to_cnt + TO_W'(1);

            if (fe) begin
                unique case (state)
                    IDLE: begin
                        // A high data line at a clock edge is not a start bit
                        if (!data_filt) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_filt, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_filt;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_filt && (^{shreg, par_bit})) begin
                            if (skip != 3'd0) begin
                                skip <= skip - 3'd1;
                            end else if (shreg == PS2_PAUSE) begin
                                skip <= PS2_PAUSE_LEN;
                                ext  <= 1'b0;
                                brk  <= 1'b0;
                            end else if (shreg == PS2_EXT) begin
                                ext <= 1'b1;
                            end else if (shreg == PS2_BRK) begin
                                brk <= 1'b1;
                            end else begin
                                ps2_key[KEY_TGL]                 <= ~ps2_key[KEY_TGL];
                                ps2_key[KEY_PRS]                 <= ~brk;
                                ps2_key[KEY_EXT]                 <= ext;
                                ps2_key[KEY_CODE_HI:KEY_CODE_LO] <= shreg;
                                key_stb                          <= 1'b1;
                                ext                              <= 1'b0;
                                brk                              <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                            skip      <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && to_cnt == TO_W'(TIMEOUT - 1)) begin
                // Keyboard stopped clocking mid-frame: abandon it
                state     <= IDLE;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_gen.sv
// Self-checking bench for ps2_key_gen: directed scenarios plus randomized
// byte streams compared against a byte-level reference model.
module tb_ps2_key_gen;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 400;

    logic        clk_sys = 1'b0;
    logic        RESET = 1'b1;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        key_stb;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    // Observed events and error pulses
    logic [10:0] cap_q[$];
    int          ferr_cnt = 0;

    // Reference model state
    logic [10:0] exp_q[$];
    logic        m_tgl = 1'b0;
    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;
    int          m_skip = 0;
    int          m_err = 0;

    ps2_key_gen #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .key_stb     (key_stb),
        .frame_err   (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (key_stb)   cap_q.push_back(ps2_key);
        if (frame_err) ferr_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic model_reset();
        m_tgl  = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_skip = 0;
    endtask

    // Byte-level meaning of a received frame
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_err++;
            m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7; m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            m_tgl = ~m_tgl;
            exp_q.push_back({m_tgl, ~m_brk, m_ext, b});
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data_in = b;
        cyc(10);
        ps2_clk_in = 1'b0;
        cyc(20);
        ps2_clk_in = 1'b1;
        cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
        cyc(20);
        model_byte(b, !bad_par);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        cyc(5);
        checks++;
        if (ps2_key !== 11'h000) begin errors++; $display("FAIL reset_key: got %h want 000", ps2_key); end
        checks++;
        if (key_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", key_stb); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        RESET = 1'b0;
        model_reset();
        cyc(5);
    endtask

    task automatic test_space();
        int c0 = cap_q.size();
        int f0 = ferr_cnt;
        send_frame(8'h29, 1'b0);
        checks++;
        if (cap_q.size() - c0 !== 1) begin
            errors++; $display("FAIL space_count: got %0d want 1", cap_q.size() - c0);
        end else begin
            checks++;
            if (cap_q[c0] !== 11'h629) begin errors++; $display("FAIL space_key: got %h want 629", cap_q[c0]); end
        end
        checks++;
        if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL space_ferr: got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_break();
        int c0 = cap_q.size();
        send_frame(8'hF0, 1'b0);
        checks++;
        if (cap_q.size() - c0 !== 0) begin errors++; $display("FAIL break_prefix_event: got %0d want 0", cap_q.size() - c0); end
        send_frame(8'h29, 1'b0);
        checks++;
        if (cap_q.size() - c0 !== 1) begin
            errors++; $display("FAIL break_count: got %0d want 1", cap_q.size() - c0);
        end else begin
            checks++;
            if (cap_q[c0] !== 11'h029) begin errors++; $display("FAIL break_key: got %h want 029", cap_q[c0]); end
        end
    endtask

    task automatic test_extended();
        int c0 = cap_q.size();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        checks++;
        if (cap_q.size() - c0 !== 2) begin
            errors++; $display("FAIL ext_count: got %0d want 2", cap_q.size() - c0);
        end else begin
            checks++;
            if (cap_q[c0] !== 11'h775) begin errors++; $display("FAIL ext_make: got %h want 775", cap_q[c0]); end
            checks++;
            if (cap_q[c0+1] !== 11'h175) begin errors++; $display("FAIL ext_break: got %h want 175", cap_q[c0+1]); end
        end
    endtask

    task automatic test_parity();
        int c0 = cap_q.size();
        int f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0);
        checks++;
        if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL parity_ferr: got %0d want 1", ferr_cnt - f0); end
        checks++;
        if (cap_q.size() - c0 !== 1) begin
            errors++; $display("FAIL parity_count: got %0d want 1", cap_q.size() - c0);
        end else begin
            checks++;
            if (cap_q[c0][7:0] !== 8'h1C || cap_q[c0][9] !== 1'b1) begin
                errors++; $display("FAIL parity_key: got %h want code 1C pressed 1", cap_q[c0]);
            end
        end
    endtask

    task automatic test_timeout();
        int c0 = cap_q.size();
        int f0 = ferr_cnt;
        int e0 = exp_q.size();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        cyc(TIMEOUT + 100);
        m_ext = 1'b0; m_brk = 1'b0;
        checks++;
        if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL timeout_ferr: got %0d want 1", ferr_cnt - f0); end
        send_frame(8'h16, 1'b0);
        checks++;
        if (cap_q.size() - c0 !== 1) begin
            errors++; $display("FAIL timeout_recover_count: got %0d want 1", cap_q.size() - c0);
        end else begin
            checks++;
            if (cap_q[c0] !== exp_q[e0]) begin
                errors++; $display("FAIL timeout_recover_key: got %h want %h", cap_q[c0], exp_q[e0]);
            end
        end
        // Short low pulse on the clock with data low must not start a frame
        f0 = ferr_cnt;
        c0 = cap_q.size();
        ps2_data_in = 1'b0;
        cyc(10);
        ps2_clk_in = 1'b0;
        cyc(3);
        ps2_clk_in = 1'b1;
        cyc(10);
        ps2_data_in = 1'b1;
        cyc(TIMEOUT + 100);
        checks++;
        if (ferr_cnt - f0 !== 0 || cap_q.size() - c0 !== 0) begin
            errors++; $display("FAIL glitch: got ferr %0d events %0d want 0 0", ferr_cnt - f0, cap_q.size() - c0);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h05};
        int c0 = cap_q.size();
        int e0 = exp_q.size();
        for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0);
        checks++;
        if (cap_q.size() - c0 !== 0) begin errors++; $display("FAIL pause_events: got %0d want 0", cap_q.size() - c0); end
        send_frame(seq[8], 1'b0);
        checks++;
        if (cap_q.size() - c0 !== 1) begin
            errors++; $display("FAIL pause_after_count: got %0d want 1", cap_q.size() - c0);
        end else begin
            checks++;
            if (cap_q[c0][7:0] !== 8'h05 || cap_q[c0] !== exp_q[e0]) begin
                errors++; $display("FAIL pause_after_key: got %h want %h", cap_q[c0], exp_q[e0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        int f0;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        ps2_clk_in = 1'b1;
        ps2_data_in = 1'b1;
        RESET = 1'b1;
        cyc(3);
        checks++;
        if (ps2_key !== 11'h000 || key_stb !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got key %h stb %b ferr %b want 000 0 0", ps2_key, key_stb, frame_err);
        end
        RESET = 1'b0;
        model_reset();
        c0 = cap_q.size();
        f0 = ferr_cnt;
        cyc(TIMEOUT + 100);
        checks++;
        if (ferr_cnt - f0 !== 0 || cap_q.size() - c0 !== 0) begin
            errors++; $display("FAIL midreset_quiet: got ferr %0d events %0d want 0 0", ferr_cnt - f0, cap_q.size() - c0);
        end
        send_frame(8'h1C, 1'b0);
        checks++;
        if (cap_q.size() - c0 !== 1) begin
            errors++; $display("FAIL midreset_next_count: got %0d want 1", cap_q.size() - c0);
        end else begin
            checks++;
            if (cap_q[c0] !== 11'h61C) begin errors++; $display("FAIL midreset_next_key: got %h want 61C", cap_q[c0]); end
        end
    endtask

    task automatic test_random();
        int c0 = cap_q.size();
        int e0 = exp_q.size();
        int me0 = m_err;
        int f0 = ferr_cnt;
        logic [7:0] b;
        bit bad;
        for (int n = 0; n < 28; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h3A;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad);
        end
        checks++;
        if (ferr_cnt - f0 !== m_err - me0) begin
            errors++; $display("FAIL random_ferr: got %0d want %0d", ferr_cnt - f0, m_err - me0);
        end
        checks++;
        if (cap_q.size() - c0 !== exp_q.size() - e0) begin
            errors++; $display("FAIL random_count: got %0d want %0d", cap_q.size() - c0, exp_q.size() - e0);
        end else begin
            for (int i = 0; i < exp_q.size() - e0; i++) begin
                checks++;
                if (cap_q[c0+i] !== exp_q[e0+i]) begin
                    errors++; $display("FAIL random_key[%0d]: got %h want %h", i, cap_q[c0+i], exp_q[e0+i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_space();
        test_break();
        test_extended();
        test_parity();
        test_timeout();
        test_pause();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
